// File: rtl/genie_conv_pkg.sv
`default_nettype none
// ============================================================================
// genie_conv_pkg
//   Shared table types and the parallel match/mux used by the field converters.
//   Rev 1.0
// ============================================================================
package genie_conv_pkg;

  localparam int c_max_n = 32;
  localparam int c_max_w = 32;

  typedef struct packed {
    logic [c_max_w-1:0] in_val;
    logic [c_max_w-1:0] out_val;
  } conv_pair_t;

  typedef struct packed {
    logic [c_max_n-1:0] match;
    logic [c_max_w-1:0] value;
  } conv_result_t;

  // All entries are compared in parallel and OR-combined; no priority,
  // so duplicate keys give an undefined mix of values.
  function automatic conv_result_t conv_match(input conv_pair_t [c_max_n-1:0] tbl,
                                              input logic [c_max_w-1:0] key,
                                              input int n);
    conv_result_t res;
    res = '0;
    for (int i = 0; i < c_max_n; i++) begin
      if ((i < n) && (key == tbl[i].out_val)) begin
        res.match[i] = 1'b1;
        res.value    = res.value | tbl[i].in_val;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/genie_skid_buf.sv
`default_nettype none
// ============================================================================
// genie_skid_buf
//   Two-register skid buffer: 1-cycle latency, full throughput, registered ready.
//   Rev 1.0
// ============================================================================
module genie_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_or_v;
  logic             r_sk_v;
  logic             r_ready;
  logic [WIDTH-1:0] r_or_d;
  logic [WIDTH-1:0] r_sk_d;

  logic w_acc;
  logic w_drain;
  logic w_or_v_nxt;
  logic w_sk_v_nxt;
  logic w_ld_or_in;
  logic w_ld_or_sk;
  logic w_ld_sk;

  assign w_acc   = i_valid && r_ready;
  assign w_drain = r_or_v && i_ready;

  // An accept can never coincide with an SK->OR move: ready is low whenever SK holds a beat.
  always_comb begin
    w_or_v_nxt = r_or_v;
    w_sk_v_nxt = r_sk_v;
    w_ld_or_in = 1'b0;
    w_ld_or_sk = 1'b0;
    w_ld_sk    = 1'b0;
    if (w_drain) begin
      w_or_v_nxt = 1'b0;
      if (r_sk_v) begin
        w_ld_or_sk = 1'b1;
        w_or_v_nxt = 1'b1;
        w_sk_v_nxt = 1'b0;
      end
    end
    if (w_acc) begin
      if (!r_or_v || w_drain) begin
        w_ld_or_in = 1'b1;
        w_or_v_nxt = 1'b1;
      end else begin
        w_ld_sk    = 1'b1;
        w_sk_v_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_or_v  <= 1'b0;
      r_sk_v  <= 1'b0;
      r_ready <= 1'b0;
      r_or_d  <= '0;
      r_sk_d  <= '0;
    end else begin
      r_or_v  <= w_or_v_nxt;
      r_sk_v  <= w_sk_v_nxt;
      r_ready <= !w_sk_v_nxt;
      if (w_ld_or_in) begin
        r_or_d <= i_data;
      end else if (w_ld_or_sk) begin
        r_or_d <= r_sk_d;
      end
      if (w_ld_sk) begin
        r_sk_d <= i_data;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_or_v;
  assign o_data  = r_or_d;

endmodule
`default_nettype wire

// File: rtl/genie_conv_inv.sv
`default_nettype none
// ============================================================================
// genie_conv_inv
//   Inverse field converter: restores the original field from a converted one.
//   Rev 1.0
// ============================================================================
module genie_conv_inv
  import genie_conv_pkg::*;
#(
  parameter int WIDTH_DATA   = 8,
  parameter int WIDTH_IN     = 8,
  parameter int WIDTH_OUT    = 8,
  parameter int N_ENTRIES    = 1,
  parameter logic [N_ENTRIES-1:0][WIDTH_IN-1:0]  IN_VALS  = '0,
  parameter logic [N_ENTRIES-1:0][WIDTH_OUT-1:0] OUT_VALS = '0,
  parameter bit DROP_MISS    = 1'b1,
  parameter int WIDTH_ERRCNT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [WIDTH_DATA-1:0]   i_data,
  input  logic [WIDTH_OUT-1:0]    i_out,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [WIDTH_DATA-1:0]   o_data,
  output logic [WIDTH_IN-1:0]     o_in,
  output logic                    o_miss,
  output logic                    o_err,
  output logic [WIDTH_ERRCNT-1:0] o_errcnt
);

  localparam int c_skid_w = 1 + WIDTH_IN + WIDTH_DATA;

  conv_pair_t [c_max_n-1:0] w_tbl;
  logic [c_max_w-1:0]       w_key;
  conv_result_t             w_res;
  logic [WIDTH_IN-1:0]      w_in;
  logic                     w_miss;
  logic                     w_accept;
  logic                     w_skid_valid;
  logic                     w_skid_ready;
  logic [c_skid_w-1:0]      w_skid_din;
  logic [c_skid_w-1:0]      w_skid_dout;
  logic                     w_unused_res;

  logic                     r_err;
  logic [WIDTH_ERRCNT-1:0]  r_errcnt;

  always_comb begin
    w_tbl = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      w_tbl[i].in_val[WIDTH_IN-1:0]   = IN_VALS[i];
      w_tbl[i].out_val[WIDTH_OUT-1:0] = OUT_VALS[i];
    end
  end

  always_comb begin
    w_key                = '0;
    w_key[WIDTH_OUT-1:0] = i_out;
  end

  assign w_res        = conv_match(w_tbl, w_key, N_ENTRIES);
  assign w_in         = w_res.value[WIDTH_IN-1:0];
  assign w_miss       = ~|w_res.match;
  assign w_unused_res = ^w_res;

  // Dropped misses still handshake upstream; they just never reach the buffer.
  assign w_accept     = i_valid && w_skid_ready;
  assign w_skid_valid = i_valid && !(DROP_MISS && w_miss);
  assign w_skid_din   = {w_miss, w_in, i_data};
  assign o_ready      = w_skid_ready;

  genie_skid_buf #(
    .WIDTH (c_skid_w)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_skid_valid),
    .o_ready (w_skid_ready),
    .i_data  (w_skid_din),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (w_skid_dout)
  );

  assign {o_miss, o_in, o_data} = w_skid_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err    <= 1'b0;
      r_errcnt <= '0;
    end else if (w_accept && w_miss) begin
      r_err <= 1'b1;
      if (r_errcnt != '1) begin
        r_errcnt <= r_errcnt + WIDTH_ERRCNT'(1);
      end
    end
  end

  assign o_err    = r_err;
  assign o_errcnt = r_errcnt;

  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (o_valid && !i_ready) |=> (o_valid && $stable(o_data) && $stable(o_in)));

  a_onehot_match: assert property (@(posedge clk) disable iff (reset)
    w_accept |-> $onehot0(w_res.match));

endmodule
`default_nettype wire

// File: tb/tb_genie_conv_inv.sv
`default_nettype none
// ============================================================================
// tb_genie_conv_inv
//   Self-checking bench: directed vector table, hand sequences, random scoreboard.
//   Rev 1.0
// ============================================================================
module tb_genie_conv_inv;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: drop misses, 8-bit counter.  DUT B: forward misses, 2-bit counter.
  logic       a_rst, a_iv, a_ordy, a_ov, a_irdy, a_miss, a_err;
  logic [7:0] a_d, a_odata, a_oin, a_cnt;
  logic [3:0] a_out;
  logic       b_rst, b_iv, b_ordy, b_ov, b_irdy, b_miss, b_err;
  logic [7:0] b_d, b_odata, b_oin;
  logic [1:0] b_cnt;
  logic [3:0] b_out;

  genie_conv_inv #(
    .WIDTH_DATA(8), .WIDTH_IN(8), .WIDTH_OUT(4), .N_ENTRIES(3),
    .IN_VALS({8'd12, 8'd11, 8'd10}), .OUT_VALS({4'd7, 4'd5, 4'd2}),
    .DROP_MISS(1'b1), .WIDTH_ERRCNT(8)
  ) u_dut_a (
    .clk(clk), .reset(a_rst), .i_valid(a_iv), .o_ready(a_ordy), .i_data(a_d),
    .i_out(a_out), .o_valid(a_ov), .i_ready(a_irdy), .o_data(a_odata),
    .o_in(a_oin), .o_miss(a_miss), .o_err(a_err), .o_errcnt(a_cnt)
  );

  genie_conv_inv #(
    .WIDTH_DATA(8), .WIDTH_IN(8), .WIDTH_OUT(4), .N_ENTRIES(3),
    .IN_VALS({8'd12, 8'd11, 8'd10}), .OUT_VALS({4'd7, 4'd5, 4'd2}),
    .DROP_MISS(1'b0), .WIDTH_ERRCNT(2)
  ) u_dut_b (
    .clk(clk), .reset(b_rst), .i_valid(b_iv), .o_ready(b_ordy), .i_data(b_d),
    .i_out(b_out), .o_valid(b_ov), .i_ready(b_irdy), .o_data(b_odata),
    .o_in(b_oin), .o_miss(b_miss), .o_err(b_err), .o_errcnt(b_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference lookup table: converted key -> original field.
  function automatic void lookup(input logic [3:0] key, output logic hit, output logic [7:0] val);
    int keys[3];
    int vals[3];
    keys = '{2, 5, 7};
    vals = '{10, 11, 12};
    hit = 1'b0;
    val = 8'd0;
    foreach (keys[i]) begin
      if (int'(key) == keys[i]) begin
        hit = 1'b1;
        val = 8'(vals[i]);
      end
    end
  endfunction

  function automatic logic [3:0] pick_key();
    case ($urandom_range(0, 3))
      0:       return 4'd2;
      1:       return 4'd5;
      2:       return 4'd7;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  typedef struct {
    logic       v;
    logic [3:0] key;
    logic [7:0] d;
    logic       rdy;
    logic       e_v;
    logic       e_rdy;
    logic [7:0] e_in;
    logic [7:0] e_d;
    logic       e_err;
    logic [7:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic v, logic [3:0] k, logic [7:0] d, logic r, logic ev,
                              logic er, logic [7:0] ei, logic [7:0] ed, logic ee, logic [7:0] ec);
    vec_t x;
    x.v = v; x.key = k; x.d = d; x.rdy = r; x.e_v = ev;
    x.e_rdy = er; x.e_in = ei; x.e_d = ed; x.e_err = ee; x.e_cnt = ec;
    return x;
  endfunction

  // Random-phase scoreboard state: {miss, in, data}
  logic [16:0] qa[$];
  logic [16:0] qb[$];
  int          acc_a, acc_b, miss_a, miss_b;
  logic        pa_stall, pb_stall;
  logic [16:0] pa_out, pb_out;

  task automatic mon_cycle();
    logic       hit;
    logic [7:0] val;
    @(negedge clk);
    if (pa_stall) chk("a_stall_hold", {a_ov, a_miss, a_oin, a_odata}, {1'b1, pa_out});
    if (pb_stall) chk("b_stall_hold", {b_ov, b_miss, b_oin, b_odata}, {1'b1, pb_out});
    if (a_ov && a_irdy) begin
      if (qa.size() == 0) chk("a_unexpected_beat", {a_miss, a_oin, a_odata}, 32'hFFFF_FFFF);
      else chk("a_beat", {a_miss, a_oin, a_odata}, qa.pop_front());
    end
    if (b_ov && b_irdy) begin
      if (qb.size() == 0) chk("b_unexpected_beat", {b_miss, b_oin, b_odata}, 32'hFFFF_FFFF);
      else chk("b_beat", {b_miss, b_oin, b_odata}, qb.pop_front());
    end
    if (a_iv && a_ordy) begin
      lookup(a_out, hit, val);
      acc_a++;
      if (hit) qa.push_back({1'b0, val, a_d});
      else miss_a++;
    end
    if (b_iv && b_ordy) begin
      lookup(b_out, hit, val);
      acc_b++;
      if (!hit) miss_b++;
      qb.push_back({!hit, val, b_d});
    end
    pa_stall = a_ov && !a_irdy;
    pb_stall = b_ov && !b_irdy;
    pa_out   = {a_miss, a_oin, a_odata};
    pb_out   = {b_miss, b_oin, b_odata};
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vt[$];
    logic [3:0] mkeys[5];
    int         cyc;

    a_rst = 1'b1; a_iv = 1'b0; a_d = '0; a_out = '0; a_irdy = 1'b0;
    b_rst = 1'b1; b_iv = 1'b0; b_d = '0; b_out = '0; b_irdy = 1'b0;
    pa_stall = 1'b0; pb_stall = 1'b0; pa_out = '0; pb_out = '0;
    acc_a = 0; acc_b = 0; miss_a = 0; miss_b = 0;

    // streaming, drop-on-miss, then back-pressure with 2 held beats and a stalled 3rd
    vt.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0,  8'h00, 0, 0));
    vt.push_back(mk(1, 5, 8'h11, 1, 0, 1, 0,  8'h00, 0, 0));
    vt.push_back(mk(1, 7, 8'h12, 1, 1, 1, 11, 8'h11, 0, 0));
    vt.push_back(mk(1, 2, 8'h13, 1, 1, 1, 12, 8'h12, 0, 0));
    vt.push_back(mk(0, 0, 8'h00, 1, 1, 1, 10, 8'h13, 0, 0));
    vt.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0,  8'h00, 0, 0));
    vt.push_back(mk(1, 5, 8'h21, 1, 0, 1, 0,  8'h00, 0, 0));
    vt.push_back(mk(1, 3, 8'h22, 1, 1, 1, 11, 8'h21, 0, 0));
    vt.push_back(mk(1, 7, 8'h23, 1, 0, 1, 0,  8'h00, 1, 1));
    vt.push_back(mk(0, 0, 8'h00, 1, 1, 1, 12, 8'h23, 1, 1));
    vt.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0,  8'h00, 1, 1));
    vt.push_back(mk(1, 5, 8'h31, 0, 0, 1, 0,  8'h00, 1, 1));
    vt.push_back(mk(1, 7, 8'h32, 0, 1, 1, 11, 8'h31, 1, 1));
    vt.push_back(mk(1, 2, 8'h33, 0, 1, 0, 11, 8'h31, 1, 1));
    vt.push_back(mk(1, 2, 8'h33, 0, 1, 0, 11, 8'h31, 1, 1));
    vt.push_back(mk(1, 2, 8'h33, 1, 1, 0, 11, 8'h31, 1, 1));
    vt.push_back(mk(1, 2, 8'h33, 1, 1, 1, 12, 8'h32, 1, 1));
    vt.push_back(mk(0, 0, 8'h00, 1, 1, 1, 10, 8'h33, 1, 1));
    vt.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0,  8'h00, 1, 1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_valid", a_ov, 0);
    chk("rst_a_ready", a_ordy, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_outs", {a_miss, a_oin, a_odata}, 0);
    chk("rst_b_valid_ready", {b_ov, b_ordy}, 0);
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;

    foreach (vt[i]) begin
      a_iv = vt[i].v; a_out = vt[i].key; a_d = vt[i].d; a_irdy = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), a_ov, vt[i].e_v);
      chk($sformatf("vec%0d_ready", i), a_ordy, vt[i].e_rdy);
      chk($sformatf("vec%0d_err", i), {a_err, a_cnt}, {vt[i].e_err, vt[i].e_cnt});
      if (vt[i].e_v) chk($sformatf("vec%0d_data", i), {a_miss, a_oin, a_odata}, {1'b0, vt[i].e_in, vt[i].e_d});
      @(posedge clk);
      #1;
    end

    // reset with OR and SK both full and downstream stalled
    a_iv = 1'b1; a_out = 4'd5; a_d = 8'h41; a_irdy = 1'b0;
    step();
    a_out = 4'd7; a_d = 8'h42;
    step();
    a_iv = 1'b0; a_rst = 1'b1;
    @(negedge clk);
    chk("full_before_rst", {a_ov, a_ordy, a_err}, {1'b1, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    @(negedge clk);
    chk("after_rst_valid", a_ov, 0);
    chk("after_rst_err", {a_err, a_cnt}, 0);
    chk("after_rst_ready_low", a_ordy, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("after_rst_ready_high", {a_ordy, a_ov}, {1'b1, 1'b0});
    @(posedge clk);
    #1;

    // forwarded misses and counter saturation on the 2-bit counter
    mkeys = '{4'd4, 4'd0, 4'd1, 4'd3, 4'd15};
    b_irdy = 1'b1;
    for (int j = 0; j < 5; j++) begin
      b_iv = 1'b1; b_out = mkeys[j]; b_d = 8'h40 + 8'(j);
      @(negedge clk);
      chk($sformatf("miss%0d_cnt", j), {b_err, b_cnt}, {(j > 0), 2'((j > 3) ? 3 : j)});
      if (j > 0) chk($sformatf("miss%0d_out", j), {b_ov, b_miss, b_oin, b_odata},
                     {1'b1, 1'b1, 8'd0, 8'h40 + 8'(j - 1)});
      @(posedge clk);
      #1;
    end
    b_iv = 1'b1; b_out = 4'd5; b_d = 8'h55;
    @(negedge clk);
    chk("miss_last_out", {b_ov, b_miss, b_oin, b_odata}, {1'b1, 1'b1, 8'd0, 8'h44});
    chk("miss_sat_cnt", {b_err, b_cnt}, {1'b1, 2'd3});
    @(posedge clk);
    #1;
    b_iv = 1'b0;
    @(negedge clk);
    chk("hit_after_miss", {b_ov, b_miss, b_oin, b_odata}, {1'b1, 1'b0, 8'd11, 8'h55});
    chk("hit_keeps_cnt", b_cnt, 3);
    @(posedge clk);
    #1;

    // randomized traffic on both DUTs against the scoreboard
    a_rst = 1'b1; b_rst = 1'b1;
    step();
    step();
    a_rst = 1'b0; b_rst = 1'b0;
    cyc = 0;
    while ((acc_a < 10000 || acc_b < 10000) && cyc < 60000) begin
      a_iv = ($urandom_range(0, 3) != 0); a_out = pick_key(); a_d = 8'($urandom_range(0, 255));
      a_irdy = ($urandom_range(0, 3) != 0);
      b_iv = ($urandom_range(0, 3) != 0); b_out = pick_key(); b_d = 8'($urandom_range(0, 255));
      b_irdy = ($urandom_range(0, 3) != 0);
      mon_cycle();
      cyc++;
    end
    a_iv = 1'b0; b_iv = 1'b0; a_irdy = 1'b1; b_irdy = 1'b1;
    repeat (4) mon_cycle();
    if (acc_a < 10000 || acc_b < 10000) chk("rand_beat_budget", 32'(acc_a < acc_b ? acc_a : acc_b), 10000);
    chk("rand_a_drained", 32'(qa.size()), 0);
    chk("rand_b_drained", 32'(qb.size()), 0);
    chk("rand_a_cnt", {a_err, a_cnt}, {(miss_a > 0), 8'((miss_a > 255) ? 255 : miss_a)});
    chk("rand_b_cnt", {b_err, b_cnt}, {(miss_b > 0), 2'((miss_b > 3) ? 3 : miss_b)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
